// File: rtl/lenet_pkg.sv
// -----------------------------------------------------------------------------
// lenet_pkg
//  Shared constants, the frame sequencer state type and a one-hot check used by
//  the LeNet-5 frame controller and its byte-to-pixel packer.
//  No ports (package).
// -----------------------------------------------------------------------------
package lenet_pkg;

  localparam int PIX_W       = 18;                 // pixel width in bits
  localparam int N_PIX       = 784;                // 28x28 pixels per frame
  localparam int ADDR_W      = 10;                 // image buffer address width
  localparam int RES_W       = 10;                 // class vector width
  localparam int FRAME_BYTES = N_PIX * PIX_W / 8;  // 1764 bytes per frame

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_e;

  // True when exactly one bit of the class vector is set.
  function automatic logic onehot10(input logic [RES_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < RES_W; i++) begin
      if (v[i]) n++;
    end
    return (n == 1);
  endfunction

endpackage

// File: rtl/byte_pixel_packer.sv
// -----------------------------------------------------------------------------
// byte_pixel_packer
//  Packs an MSB-first byte stream into PIX_W-bit pixels. Each accepted byte is
//  shifted into a 25-bit accumulator; whenever 18 or more bits are held, the
//  oldest 18 are emitted as a pixel on the following cycle (registered output).
//  Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             drop any partially assembled pixel
//   in_valid        in_byte is valid this cycle
//   in_byte [7:0]   next byte of the stream
//   out_valid       one-cycle strobe: out_pix holds a completed pixel
//   out_pix [17:0]  completed pixel
// -----------------------------------------------------------------------------
module byte_pixel_packer
  import lenet_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_pix
);

  // Up to 17 leftover bits plus one new byte.
  localparam int ACC_W = PIX_W + 7;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam logic [CNT_W-1:0] PIX_W_C = CNT_W'(PIX_W);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_pix_q, out_pix_d;

  logic [ACC_W-1:0] acc_shift;
  logic [CNT_W-1:0] cnt_sum;

  always_comb begin
    acc_shift   = {acc_q[ACC_W-9:0], in_byte};
    cnt_sum     = cnt_q + CNT_W'(8);
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_pix_d   = out_pix_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (in_valid) begin
      acc_d = acc_shift;
      if (cnt_sum >= PIX_W_C) begin
        // Oldest 18 held bits sit at acc[cnt-1 -: 18]; shift them down to bit 0.
        out_valid_d = 1'b1;
        out_pix_d   = PIX_W'(acc_shift >> (cnt_sum - PIX_W_C));
        cnt_d       = cnt_sum - PIX_W_C;
      end else begin
        cnt_d = cnt_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_pix_q   <= out_pix_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pix   = out_pix_q;

endmodule

// File: rtl/lenet_frame_ctrl.sv
// -----------------------------------------------------------------------------
// lenet_frame_ctrl
//  Frame sequencer between the UART byte receiver and the LeNet-5 core. Loads
//  a 1764-byte frame into the image buffer as 784 18-bit pixels, starts the
//  core, waits for its result and holds the class vector until the next frame
//  or a later_read re-run of the stored frame.
//  Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rx_valid/rx_byte  received byte strobe and data
//   mem_we/addr/wdata image buffer write port
//   net_start         one-cycle start pulse to the core
//   net_done/result   completion strobe and class vector from the core
//   later_read        re-run inference on the stored frame
//   finish/outnum     result held / latched class vector
//   busy              high while loading or running
//   err               sticky overrun / timeout / non-one-hot flag
// -----------------------------------------------------------------------------
module lenet_frame_ctrl
  import lenet_pkg::*;
#(
  parameter int GAP_CYC = 50000,
  parameter int RUN_CYC = 16777215
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  output logic              net_start,
  input  logic              net_done,
  input  logic [RES_W-1:0]  net_result,
  input  logic              later_read,
  output logic              finish,
  output logic [RES_W-1:0]  outnum,
  output logic              busy,
  output logic              err
);

  localparam int BYTE_W = $clog2(FRAME_BYTES + 1);
  localparam int GAP_W  = $clog2(GAP_CYC + 1);
  localparam int RUN_W  = $clog2(RUN_CYC + 1);

  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(FRAME_BYTES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(RUN_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_PIX - 1);

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                frame_valid_q, frame_valid_d;
  logic                net_start_q, net_start_d;
  logic                finish_q, finish_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [RES_W-1:0]    outnum_q, outnum_d;

  logic                pk_clr;
  logic                pk_valid;
  logic                pk_out_valid;
  logic [PIX_W-1:0]    pk_out_pix;

  // Bytes only reach the packer in states that accept them; bytes arriving
  // while the core runs are dropped.
  assign pk_valid = rx_valid && ((state_q == IDLE) || (state_q == LOAD) || (state_q == DONE));

  byte_pixel_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (pk_clr),
    .in_valid  (pk_valid),
    .in_byte   (rx_byte),
    .out_valid (pk_out_valid),
    .out_pix   (pk_out_pix)
  );

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    gap_d         = gap_q;
    run_d         = run_q;
    addr_d        = addr_q;
    frame_valid_d = frame_valid_q;
    err_d         = err_q;
    outnum_d      = outnum_q;
    net_start_d   = 1'b0;
    pk_clr        = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (rx_valid) begin
          // First byte of a new frame; it is consumed by the packer now.
          // The buffer is being overwritten, so the stored frame is gone.
          state_d       = LOAD;
          byte_cnt_d    = BYTE_W'(1);
          gap_d         = '0;
          addr_d        = '0;
          frame_valid_d = 1'b0;
        end else if ((state_q == DONE) && later_read && frame_valid_q) begin
          // Re-run: the start pulse is issued straight from DONE so it
          // appears one cycle after later_read is taken.
          net_start_d = 1'b1;
          err_d       = 1'b0;
          run_d       = '0;
          state_d     = WAIT;
        end
      end

      LOAD: begin
        if (rx_valid) begin
          gap_d = '0;
          if (byte_cnt_q == BYTE_LAST) begin
            byte_cnt_d    = '0;
            frame_valid_d = 1'b1;
            state_d       = RUN;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end else if (gap_q == GAP_LAST) begin
          // Sender stalled: abandon the partial frame silently.
          byte_cnt_d = '0;
          gap_d      = '0;
          addr_d     = '0;
          pk_clr     = 1'b1;
          state_d    = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      RUN: begin
        net_start_d = 1'b1;
        err_d       = 1'b0;
        run_d       = '0;
        state_d     = WAIT;
      end

      WAIT: begin
        if (net_done) begin
          outnum_d = net_result;
          err_d    = err_q | ~onehot10(net_result);
          state_d  = DONE;
        end else if (run_q == RUN_LAST) begin
          outnum_d = '0;
          err_d    = 1'b1;
          state_d  = DONE;
        end else begin
          run_d = run_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Overrun: a byte while the core is busy is dropped and flagged.
    if (rx_valid && ((state_q == RUN) || (state_q == WAIT))) begin
      err_d = 1'b1;
    end

    // The write address tracks the pixel currently on the write port and
    // wraps after the last pixel so it never leaves 0..N_PIX-1.
    if (pk_out_valid) begin
      addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
    end

    busy_d   = (state_d == LOAD) || (state_d == RUN) || (state_d == WAIT);
    finish_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      byte_cnt_q    <= '0;
      gap_q         <= '0;
      run_q         <= '0;
      addr_q        <= '0;
      frame_valid_q <= 1'b0;
      net_start_q   <= 1'b0;
      finish_q      <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      outnum_q      <= '0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      gap_q         <= gap_d;
      run_q         <= run_d;
      addr_q        <= addr_d;
      frame_valid_q <= frame_valid_d;
      net_start_q   <= net_start_d;
      finish_q      <= finish_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      outnum_q      <= outnum_d;
    end
  end

  assign mem_we    = pk_out_valid;
  assign mem_addr  = addr_q;
  assign mem_wdata = pk_out_pix;
  assign net_start = net_start_q;
  assign finish    = finish_q;
  assign outnum    = outnum_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
